// File: rtl/display_digit_scanner.sv
// Time-multiplexes a packed BCD value onto one shared 7-segment decoder; new values commit only at frame boundaries.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module display_digit_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    enable,
  output logic [3:0]              digit_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

  typedef enum logic {ST_WAIT, ST_SCAN} state_t;

  state_t                  state;
  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] disp;
  logic                    pending;

  logic                    tick;
  logic                    wrap;
  logic [IW-1:0]           idx_next;
  logic [4*NUM_DIGITS-1:0] disp_next;
  logic [3:0]              nibble_next;
  logic                    blank_next;
  logic [3:0]              digit_sel;
  logic [NUM_DIGITS-1:0]   an_sel;
`ifdef LEADING_ZERO_BLANK_EN
  logic                    lead_zero;
`endif

  // Next-slot view: outputs always reflect the idx and disp that take effect on this edge.
  always_comb begin
    tick      = (presc == PRESC_MAX);
    wrap      = tick && (idx == IDX_MAX);
    idx_next  = idx;
    if (tick) begin
      idx_next = wrap ? '0 : idx + IW'(1);
    end
    disp_next = (wrap && pending) ? shadow : disp;

    nibble_next = 4'hF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_next == IW'(i)) begin
        nibble_next = disp_next[4*i +: 4];
      end
    end

    blank_next = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; a slot is blank while everything above it is zero.
    lead_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lead_zero = lead_zero && (disp_next[4*i +: 4] == 4'h0);
      if ((idx_next == IW'(i)) && lead_zero) begin
        blank_next = 1'b1;
      end
    end
`endif

    digit_sel = blank_next ? 4'hF : nibble_next;
    an_sel    = (enable && !blank_next) ? ~(NUM_DIGITS'(1) << idx_next) : '1;
  end

  // Outputs stay at reset values until the first wrap brings the scan to digit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_WAIT;
      presc       <= '0;
      idx         <= '0;
      shadow      <= '0;
      disp        <= '0;
      pending     <= 1'b0;
      an          <= '1;
      digit_out   <= 4'hF;
      frame_start <= 1'b0;
    end else begin
      presc       <= tick ? '0 : presc + PW'(1);
      idx         <= idx_next;
      disp        <= disp_next;
      frame_start <= wrap;

      if (load) begin
        shadow  <= value_in;
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end

      if (wrap) begin
        state <= ST_SCAN;
      end

      if ((state == ST_SCAN) || wrap) begin
        digit_out <= digit_sel;
        an        <= an_sel;
      end
    end
  end

endmodule

// File: tb/tb_display_digit_scanner.sv
// Self-checking bench for display_digit_scanner: directed slot table, corner sequences and a random run against a model.
module tb_display_digit_scanner;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int FRAME = N * R;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value_in = 16'h0;
  logic        load = 1'b0;
  logic        enable = 1'b1;
  logic [3:0]  digit_out;
  logic [3:0]  an;
  logic        frame_start;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: edges since reset plus the buffered/displayed values.
  int          m_k;
  logic [15:0] m_shadow;
  logic [15:0] m_disp;
  logic        m_pending;
  logic [3:0]  m_an;
  logic [3:0]  m_digit;
  logic        m_fs;

  typedef struct {
    logic        ld;
    logic [15:0] val;
    logic        en;
    logic [3:0]  exp_an;
    logic [3:0]  exp_digit;
  } vec_t;

  vec_t vecs [28];

  display_digit_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .load        (load),
    .enable      (enable),
    .digit_out   (digit_out),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    m_k       = 0;
    m_shadow  = 16'h0;
    m_disp    = 16'h0;
    m_pending = 1'b0;
    m_an      = 4'b1111;
    m_digit   = 4'hF;
    m_fs      = 1'b0;
  endtask

  // Slot index comes straight from elapsed time: idx = (edges / R) mod N.
  task automatic modelAdvance();
    int   slot;
    logic blank;
    if (reset) begin
      modelReset();
      return;
    end
    m_k++;
    m_fs = (m_k % FRAME == 0);
    if (m_fs && m_pending) begin
      m_disp    = m_shadow;
      m_pending = 1'b0;
    end
    if (load) begin
      m_shadow  = value_in;
      m_pending = 1'b1;
    end
    if (m_k >= FRAME) begin
      slot    = (m_k / R) % N;
      blank   = LZB && (slot > 0) && ((m_disp >> (4*slot)) == 16'h0);
      m_digit = blank ? 4'hF : 4'((m_disp >> (4*slot)) & 16'hF);
      m_an    = (enable && !blank) ? ~(4'b0001 << slot) : 4'b1111;
    end
  endtask

  task automatic compareModel();
    checkOutput("model_an", 32'(an), 32'(m_an));
    checkOutput("model_digit", 32'(digit_out), 32'(m_digit));
    checkOutput("model_frame_start", 32'(frame_start), 32'(m_fs));
  endtask

  task automatic applyStimulus(input logic ld, input logic [15:0] val, input logic en);
    load     = ld;
    value_in = val;
    enable   = en;
  endtask

  task automatic step();
    modelAdvance();
    @(posedge clk);
    @(negedge clk);
    compareModel();
  endtask

  logic [3:0] exp_an_a [4];
  logic [3:0] exp_dg_a [4];
  logic [3:0] exp_an_b [4];
  logic [3:0] exp_dg_b [4];

  initial begin
    vecs[0]  = '{1'b0, 16'h0000, 1'b1, 4'b1110, 4'h4};
    vecs[1]  = '{1'b0, 16'h0000, 1'b1, 4'b1101, 4'h3};
    vecs[2]  = '{1'b1, 16'h5678, 1'b1, 4'b1011, 4'h2};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 4'b0111, 4'h1};
    vecs[4]  = '{1'b0, 16'h0000, 1'b1, 4'b1110, 4'h8};
    vecs[5]  = '{1'b1, 16'h1111, 1'b1, 4'b1101, 4'h7};
    vecs[6]  = '{1'b0, 16'h0000, 1'b1, 4'b1011, 4'h6};
    vecs[7]  = '{1'b0, 16'h0000, 1'b1, 4'b0111, 4'h5};
    vecs[8]  = '{1'b1, 16'h9999, 1'b1, 4'b1110, 4'h1};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 4'b1101, 4'h1};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 4'b1011, 4'h1};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 4'b0111, 4'h1};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 4'b1110, 4'h9};
    vecs[13] = '{1'b0, 16'h0000, 1'b1, 4'b1101, 4'h9};
    vecs[14] = '{1'b0, 16'h0000, 1'b1, 4'b1011, 4'h9};
    vecs[15] = '{1'b0, 16'h0000, 1'b1, 4'b0111, 4'h9};
    vecs[16] = '{1'b0, 16'h0000, 1'b0, 4'b1111, 4'h9};
    vecs[17] = '{1'b1, 16'h1357, 1'b0, 4'b1111, 4'h9};
    vecs[18] = '{1'b1, 16'h2468, 1'b0, 4'b1111, 4'h9};
    vecs[19] = '{1'b0, 16'h0000, 1'b0, 4'b1111, 4'h9};
    vecs[20] = '{1'b0, 16'h0000, 1'b0, 4'b1111, 4'h8};
    vecs[21] = '{1'b0, 16'h0000, 1'b0, 4'b1111, 4'h6};
    vecs[22] = '{1'b0, 16'h0000, 1'b0, 4'b1111, 4'h4};
    vecs[23] = '{1'b0, 16'h0000, 1'b0, 4'b1111, 4'h2};
    vecs[24] = '{1'b0, 16'h0000, 1'b1, 4'b1110, 4'h8};
    vecs[25] = '{1'b0, 16'h0000, 1'b1, 4'b1101, 4'h6};
    vecs[26] = '{1'b0, 16'h0000, 1'b1, 4'b1011, 4'h4};
    vecs[27] = '{1'b0, 16'h0000, 1'b1, 4'b0111, 4'h2};

`ifdef LEADING_ZERO_BLANK_EN
    exp_an_a = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    exp_dg_a = '{4'h0, 4'h5, 4'hF, 4'hF};
    exp_an_b = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    exp_dg_b = '{4'h0, 4'hF, 4'hF, 4'hF};
`else
    exp_an_a = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_dg_a = '{4'h0, 4'h5, 4'h0, 4'h0};
    exp_an_b = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_dg_b = '{4'h0, 4'h0, 4'h0, 4'h0};
`endif

    modelReset();
    #1 reset = 1'b1;
    #1;
    checkOutput("reset_an", 32'(an), 32'hF);
    checkOutput("reset_digit", 32'(digit_out), 32'hF);
    checkOutput("reset_frame_start", 32'(frame_start), 32'h0);
    step();
    step();
    reset = 1'b0;

    $display("[TB] directed slot table");
    applyStimulus(1'b1, 16'h1234, 1'b1);
    step();
    applyStimulus(1'b0, 16'h1234, 1'b1);
    while (m_k < FRAME - 1) step();
    checkOutput("prescan_an", 32'(an), 32'hF);
    checkOutput("prescan_digit", 32'(digit_out), 32'hF);

    for (int r = 0; r < 28; r++) begin
      applyStimulus(vecs[r].ld, vecs[r].val, vecs[r].en);
      for (int c = 0; c < R; c++) begin
        step();
        if (c == 0) applyStimulus(1'b0, vecs[r].val, vecs[r].en);
        checkOutput($sformatf("row%0d_an", r), 32'(an), 32'(vecs[r].exp_an));
        checkOutput($sformatf("row%0d_digit", r), 32'(digit_out), 32'(vecs[r].exp_digit));
        checkOutput($sformatf("row%0d_fs", r), 32'(frame_start), 32'((r % N == 0) && (c == 0)));
      end
    end

    $display("[TB] random run");
    for (int i = 0; i < 1200; i++) begin
      applyStimulus($urandom_range(0, 5) == 0,
                    16'($urandom) >> (4 * $urandom_range(0, 3)),
                    $urandom_range(0, 7) != 0);
      step();
    end

    $display("[TB] reset mid-frame");
    applyStimulus(1'b0, 16'h0, 1'b1);
    reset = 1'b1;
    modelReset();
    step();
    reset = 1'b0;
    applyStimulus(1'b1, 16'h4321, 1'b1);
    step();
    applyStimulus(1'b0, 16'h4321, 1'b1);
    while (m_k < FRAME) step();
    checkOutput("s5_slot0_an", 32'(an), 32'b1110);
    checkOutput("s5_slot0_digit", 32'(digit_out), 32'h1);
    applyStimulus(1'b1, 16'h8765, 1'b1);
    step();
    applyStimulus(1'b0, 16'h8765, 1'b1);
    while (m_k < 25) step();
    checkOutput("s5_slot2_an", 32'(an), 32'b1011);
    checkOutput("s5_slot2_digit", 32'(digit_out), 32'h3);
    #2 reset = 1'b1;
    modelReset();
    #1;
    checkOutput("s5_async_an", 32'(an), 32'hF);
    checkOutput("s5_async_digit", 32'(digit_out), 32'hF);
    checkOutput("s5_async_fs", 32'(frame_start), 32'h0);
    step();
    reset = 1'b0;
    while (m_k < FRAME) step();
    checkOutput("s5_after_an", 32'(an), 32'b1110);
    checkOutput("s5_after_digit", 32'(digit_out), 32'h0);
    while (m_k < FRAME + R) step();
    checkOutput("s5_after_slot1_an", 32'(an), LZB ? 32'b1111 : 32'b1101);
    checkOutput("s5_after_slot1_digit", 32'(digit_out), LZB ? 32'hF : 32'h0);

    $display("[TB] leading zero handling");
    applyStimulus(1'b1, 16'h0050, 1'b1);
    step();
    applyStimulus(1'b0, 16'h0050, 1'b1);
    while (m_k < 2*FRAME - 1) step();
    for (int s = 0; s < N; s++) begin
      step();
      checkOutput($sformatf("lz0050_s%0d_an", s), 32'(an), 32'(exp_an_a[s]));
      checkOutput($sformatf("lz0050_s%0d_digit", s), 32'(digit_out), 32'(exp_dg_a[s]));
      repeat (R - 1) step();
    end
    applyStimulus(1'b1, 16'h0000, 1'b1);
    step();
    applyStimulus(1'b0, 16'h0000, 1'b1);
    while (m_k < 4*FRAME - 1) step();
    for (int s = 0; s < N; s++) begin
      step();
      checkOutput($sformatf("lz0000_s%0d_an", s), 32'(an), 32'(exp_an_b[s]));
      checkOutput($sformatf("lz0000_s%0d_digit", s), 32'(digit_out), 32'(exp_dg_b[s]));
      repeat (R - 1) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
